bram_rd_arb: RTL and testbench

- Shares the single read port of bram_top among NUM_STREAMS independent stream readers in the multi-stream buffer.
- Round-robin arbitration on the request side; requests forwarded to bram_top unchanged.
- Records the stream id of every issued read in an in-order tag FIFO and steers each bram_top response back to the stream that issued it.
- Sits in the clk1x domain directly in front of bram_top's i_v/i_r/i_d and o_v/o_r/o_d.

---
 rtl/bram_pkg.sv | 16 +
 rtl/bram_tag_fifo.sv | 63 ++++++
 rtl/bram_rd_arb.sv | 108 ++++++++++
 tb/tb_bram_rd_arb.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared geometry of the multi-stream BRAM buffer and the stream id type
// used by the read-port arbiter and its tag FIFO.
package bram_pkg;

    localparam int DATA_WIDTH    = 64;
    localparam int WAYS          = 8;
    localparam int RAM_DEPTH     = 512;
    localparam int ADDR_WIDTH    = $clog2(RAM_DEPTH);
    localparam int WAYS_WIDTH    = $clog2(WAYS);
    localparam int RD_ADDR_WIDTH = WAYS_WIDTH + ADDR_WIDTH - 1;
    localparam int RSP_WIDTH     = 2 * DATA_WIDTH;
    localparam int N_STREAMS     = 4;

    typedef logic [$clog2(N_STREAMS)-1:0] stream_id_t;

endpackage

// File: rtl/bram_tag_fifo.sv
// In-order FIFO of stream ids, one entry per read issued to bram_top.
// Pushes while full and pops while empty are ignored.
module bram_tag_fifo
    import bram_pkg::*;
#(
    parameter int WIDTH = $bits(stream_id_t),
    parameter int DEPTH = 8
) (
    input  logic                     clk1x,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk1x) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge clk1x) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bram_rd_arb.sv
// Round-robin arbiter sharing bram_top's read port among NUM_STREAMS readers;
// a tag FIFO remembers who issued each read so responses go back in order.
module bram_rd_arb
    import bram_pkg::*;
#(
    parameter int NUM_STREAMS   = bram_pkg::N_STREAMS,
    parameter int RD_ADDR_WIDTH = bram_pkg::RD_ADDR_WIDTH,
    parameter int RSP_WIDTH     = bram_pkg::RSP_WIDTH,
    parameter int TAG_DEPTH     = 8
) (
    input  logic                                 clk1x,
    input  logic                                 reset,
    input  logic [NUM_STREAMS-1:0]               s_v,
    output logic [NUM_STREAMS-1:0]               s_r,
    input  logic [NUM_STREAMS*RD_ADDR_WIDTH-1:0] s_d,
    output logic                                 m_v,
    input  logic                                 m_r,
    output logic [RD_ADDR_WIDTH-1:0]             m_d,
    input  logic                                 b_v,
    output logic                                 b_r,
    input  logic [RSP_WIDTH-1:0]                 b_d,
    output logic [NUM_STREAMS-1:0]               r_v,
    input  logic [NUM_STREAMS-1:0]               r_r,
    output logic [RSP_WIDTH-1:0]                 r_d,
    output logic [$clog2(TAG_DEPTH):0]           inflight,
    output logic                                 err
);

    localparam int IDW = $clog2(NUM_STREAMS);

    logic [IDW-1:0]             r_ptr;
    logic                       r_err;
    logic [IDW-1:0]             w_cand;
    logic                       w_any;
    logic                       w_issue;
    logic                       w_pop;
    logic                       w_full;
    logic                       w_empty;
    logic [IDW-1:0]             w_head;
    logic [$clog2(TAG_DEPTH):0] w_count;

    // Scan from the farthest offset down so the nearest requester from r_ptr wins.
    always_comb begin
        logic [IDW-1:0] v_idx;
        w_cand = '0;
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            v_idx = r_ptr + IDW'(i);
            if (s_v[v_idx]) begin
                w_cand = v_idx;
            end
        end
    end

    assign w_any   = |s_v;
    assign m_v     = w_any & ~w_full;
    assign m_d     = s_d[w_cand*RD_ADDR_WIDTH +: RD_ADDR_WIDTH];
    assign w_issue = m_v & m_r;

    always_comb begin
        s_r = '0;
        if (w_any & m_r & ~w_full) begin
            s_r[w_cand] = 1'b1;
        end
    end

    always_comb begin
        r_v = '0;
        if (b_v & ~w_empty) begin
            r_v[w_head] = 1'b1;
        end
    end

    assign b_r      = ~w_empty & r_r[w_head];
    assign r_d      = b_d;
    assign w_pop    = b_v & b_r;
    assign inflight = w_count;
    assign err      = r_err;

    always_ff @(posedge clk1x) begin
        if (reset) begin
            r_ptr <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_issue) begin
                r_ptr <= w_cand + IDW'(1);
            end
            if (b_v & w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    bram_tag_fifo #(
        .WIDTH (IDW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk1x   (clk1x),
        .reset   (reset),
        .i_push  (w_issue),
        .i_pop   (w_pop),
        .i_din   (w_cand),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_bram_rd_arb.sv
// Bench for bram_rd_arb: a scoreboard of issued reads supplies the expected
// stream and data for every response presented on the bram_top side.
module tb_bram_rd_arb;

    localparam int NS = 4;
    localparam int AW = 11;
    localparam int DW = 128;

    logic             clk1x;
    logic             reset;
    logic [NS-1:0]    s_v;
    logic [NS-1:0]    s_r;
    logic [NS*AW-1:0] s_d;
    logic             m_v;
    logic             m_r;
    logic [AW-1:0]    m_d;
    logic             b_v;
    logic             b_r;
    logic [DW-1:0]    b_d;
    logic [NS-1:0]    r_v;
    logic [NS-1:0]    r_r;
    logic [DW-1:0]    r_d;
    logic [3:0]       inflight;
    logic             err;

    typedef struct {
        logic [1:0]    stream;
        logic [DW-1:0] data;
    } sbEntry_t;

    sbEntry_t sb[$];
    int       checkCount = 0;
    int       passCount  = 0;
    int       expPtr     = 0;

    bram_rd_arb dut (
        .clk1x    (clk1x),
        .reset    (reset),
        .s_v      (s_v),
        .s_r      (s_r),
        .s_d      (s_d),
        .m_v      (m_v),
        .m_r      (m_r),
        .m_d      (m_d),
        .b_v      (b_v),
        .b_r      (b_r),
        .b_d      (b_d),
        .r_v      (r_v),
        .r_r      (r_r),
        .r_d      (r_d),
        .inflight (inflight),
        .err      (err)
    );

    initial clk1x = 1'b0;
    always #5 clk1x = ~clk1x;

    // Stand-in for bram_top's memory contents: data derived from the address.
    function automatic logic [DW-1:0] dataOf(input logic [AW-1:0] addr);
        return {8{{5'h1B, addr}}};
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk1x);
        #1;
    endtask

    task automatic doReset(input int cycles);
        reset = 1'b1;
        s_v   = '0;
        s_d   = '0;
        m_r   = 1'b0;
        b_v   = 1'b0;
        b_d   = '0;
        r_r   = '0;
        repeat (cycles) tick();
        reset = 1'b0;
        sb.delete();
        expPtr = 0;
    endtask

    task automatic setAddr(input int k, input logic [AW-1:0] addr);
        s_d[k*AW +: AW] = addr;
    endtask

    // Single-stream request: checks the zero-latency grant, then issues it.
    task automatic applyStimulus(input int k, input logic [AW-1:0] addr);
        sbEntry_t e;
        s_v = '0;
        s_v[k] = 1'b1;
        setAddr(k, addr);
        m_r = 1'b1;
        @(negedge clk1x);
        checkOutput("req_m_v", DW'(m_v), DW'(1'b1));
        checkOutput("req_m_d", DW'(m_d), DW'(addr));
        checkOutput("req_s_r", DW'(s_r), DW'(4'(1) << k));
        e.stream = 2'(k);
        e.data   = dataOf(addr);
        sb.push_back(e);
        tick();
        s_v = '0;
        m_r = 1'b0;
    endtask

    // Present the scoreboard head as a bram_top response for one cycle.
    task automatic respondOne(input logic [NS-1:0] rrMask);
        sbEntry_t e;
        if (sb.size() == 0) begin
            checkOutput("sb_underflow", DW'(0), DW'(1));
            return;
        end
        e   = sb[0];
        b_v = 1'b1;
        b_d = e.data;
        r_r = rrMask;
        @(negedge clk1x);
        checkOutput("rsp_r_v", DW'(r_v), DW'(4'(1) << e.stream));
        checkOutput("rsp_r_d", r_d, e.data);
        checkOutput("rsp_b_r", DW'(b_r), DW'(rrMask[e.stream]));
        tick();
        if (rrMask[e.stream]) begin
            void'(sb.pop_front());
        end
        b_v = 1'b0;
        r_r = '0;
    endtask

    initial begin
        sbEntry_t e;

        // Reset state
        doReset(2);
        @(negedge clk1x);
        checkOutput("rst_m_v", DW'(m_v), DW'(0));
        checkOutput("rst_b_r", DW'(b_r), DW'(0));
        checkOutput("rst_r_v", DW'(r_v), DW'(0));
        checkOutput("rst_s_r", DW'(s_r), DW'(0));
        checkOutput("rst_inflight", DW'(inflight), DW'(0));
        checkOutput("rst_err", DW'(err), DW'(0));
        tick();

        // Single request from stream 2
        applyStimulus(2, 11'h0A0);
        @(negedge clk1x);
        checkOutput("single_inflight", DW'(inflight), DW'(1));
        tick();
        respondOne(4'b1111);
        @(negedge clk1x);
        checkOutput("single_drained", DW'(inflight), DW'(0));
        tick();

        // Fairness with all four streams requesting, filling the tag FIFO
        doReset(1);
        for (int k = 0; k < NS; k++) setAddr(k, 11'(11'h100 + k * 3));
        s_v = 4'b1111;
        m_r = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk1x);
            checkOutput("rr_s_r", DW'(s_r), DW'(4'(1) << expPtr));
            checkOutput("rr_m_d", DW'(m_d), DW'(11'h100 + expPtr * 3));
            e.stream = 2'(expPtr);
            e.data   = dataOf(11'(11'h100 + expPtr * 3));
            sb.push_back(e);
            expPtr = (expPtr + 1) % NS;
            tick();
        end

        // Full: the ninth request must wait
        @(negedge clk1x);
        checkOutput("full_inflight", DW'(inflight), DW'(8));
        checkOutput("full_m_v", DW'(m_v), DW'(0));
        checkOutput("full_s_r", DW'(s_r), DW'(0));
        tick();
        respondOne(4'b0000);
        respondOne(4'b0001);
        @(negedge clk1x);
        checkOutput("after_pop_inflight", DW'(inflight), DW'(7));
        checkOutput("after_pop_m_v", DW'(m_v), DW'(1));
        checkOutput("after_pop_s_r", DW'(s_r), DW'(4'(1) << expPtr));
        e.stream = 2'(expPtr);
        e.data   = dataOf(11'(11'h100 + expPtr * 3));
        sb.push_back(e);
        tick();
        s_v = '0;
        m_r = 1'b0;
        while (sb.size() > 0) respondOne(4'b1111);
        @(negedge clk1x);
        checkOutput("fair_drained", DW'(inflight), DW'(0));
        tick();

        // Ordering across streams, with a stall on the head stream
        doReset(1);
        applyStimulus(1, 11'h0A0);
        applyStimulus(3, 11'h140);
        respondOne(4'b1101);
        respondOne(4'b1111);
        respondOne(4'b0111);
        respondOne(4'b1111);
        @(negedge clk1x);
        checkOutput("order_drained", DW'(inflight), DW'(0));
        tick();

        // Orphaned response sets a sticky error
        doReset(1);
        b_v = 1'b1;
        b_d = dataOf(11'h7FF);
        r_r = 4'b1111;
        @(negedge clk1x);
        checkOutput("orphan_b_r", DW'(b_r), DW'(0));
        checkOutput("orphan_r_v", DW'(r_v), DW'(0));
        tick();
        b_v = 1'b0;
        r_r = '0;
        @(negedge clk1x);
        checkOutput("orphan_err", DW'(err), DW'(1));
        repeat (3) tick();
        @(negedge clk1x);
        checkOutput("orphan_err_sticky", DW'(err), DW'(1));
        tick();
        doReset(1);
        @(negedge clk1x);
        checkOutput("err_cleared", DW'(err), DW'(0));
        tick();

        // Reset with three reads in flight
        applyStimulus(0, 11'h010);
        applyStimulus(1, 11'h020);
        applyStimulus(2, 11'h030);
        @(negedge clk1x);
        checkOutput("mid_inflight", DW'(inflight), DW'(3));
        tick();
        doReset(1);
        b_v = 1'b1;
        b_d = dataOf(11'h010);
        r_r = 4'b1111;
        s_v = 4'b1001;
        setAddr(0, 11'h055);
        setAddr(3, 11'h066);
        m_r = 1'b1;
        @(negedge clk1x);
        checkOutput("mid_rst_inflight", DW'(inflight), DW'(0));
        checkOutput("mid_rst_r_v", DW'(r_v), DW'(0));
        checkOutput("mid_rst_grant", DW'(s_r), DW'(4'b0001));
        checkOutput("mid_rst_m_d", DW'(m_d), DW'(11'h055));
        e.stream = 2'd0;
        e.data   = dataOf(11'h055);
        sb.push_back(e);
        tick();
        s_v = '0;
        m_r = 1'b0;
        b_v = 1'b0;
        r_r = '0;
        @(negedge clk1x);
        checkOutput("mid_err", DW'(err), DW'(1));
        tick();
        respondOne(4'b1111);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
